movegen_sequencer: RTL and testbench

- Drives the control side of the 64-cell square array and collects its results.
- Pulses `load_attackers` once, then walks the side-to-move's pieces one origin at a time. For each origin it asserts a one-hot `emit_move` and captures the 64 `target_square` flags.
- Serialises the resulting (from, to) pairs onto a valid/ready move stream for the search/move-list logic.
- Square index = (RANK-1)*8 + (FILE-1): a1=0, e1=4, h8=63.

---
 rtl/movegen_pkg.sv | 31 +++
 rtl/lsb_index_enc.sv | 20 ++
 rtl/movegen_sequencer.sv | 164 ++++++++++++++++
 tb/tb_movegen_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generation sequencer.
package movegen_pkg;

  localparam int unsigned NUM_SQ     = 64;
  localparam int unsigned SQ_W       = 6;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned MOVE_CNT_W = 7;

  typedef logic [SQ_W-1:0]   sq_idx_t;
  typedef logic [NUM_SQ-1:0] sq_mask_t;

  typedef struct packed {
    sq_idx_t from;
    sq_idx_t to;
  } move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_SCAN,
    ST_SETTLE,
    ST_EMIT,
    ST_DONE
  } seq_state_t;

  // Square index from 1-based rank/file: a1=0, h8=63.
  function automatic sq_idx_t sq_index(input logic [3:0] rank, input logic [3:0] file);
    return {3'(rank - 4'd1), 3'(file - 4'd1)};
  endfunction

endpackage

// File: rtl/lsb_index_enc.sv
// Lowest-set-bit encoder over a 64-bit square mask.
module lsb_index_enc
  import movegen_pkg::*;
(
  input  sq_mask_t mask_i,
  output sq_idx_t  index_c_o,
  output logic     any_c_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index_c_o = '0;
    for (int i = NUM_SQ - 1; i >= 0; i--) begin
      if (mask_i[i]) index_c_o = SQ_W'(i);
    end
  end

  assign any_c_o = |mask_i;

endmodule

// File: rtl/movegen_sequencer.sv
// Walks side-to-move origins through the square array and serialises (from, to) moves.
// Optional saturating move counter output when MOVEGEN_MOVE_COUNT_EN is defined.
module movegen_sequencer
  import movegen_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [NUM_SQ-1:0]     i_play_mask,
  output logic                  o_load_attackers,
  output logic [NUM_SQ-1:0]     o_emit_move,
  input  logic [NUM_SQ-1:0]     i_target,
  output logic                  o_move_valid,
  input  logic                  i_move_ready,
  output logic [SQ_W-1:0]       o_move_from,
  output logic [SQ_W-1:0]       o_move_to,
  output logic                  o_busy,
  output logic                  o_done
`ifdef MOVEGEN_MOVE_COUNT_EN
  ,
  output logic [MOVE_CNT_W-1:0] o_move_count
`endif
);

  localparam sq_mask_t SQ_ONE = sq_mask_t'(1);

  seq_state_t             state_q, state_d;
  sq_mask_t               remaining_q, remaining_d;
  sq_mask_t               tgt_q, tgt_d;
  sq_idx_t                origin_q, origin_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  sq_idx_t                rem_idx_c;
  logic                   rem_any_c;
  sq_idx_t                tgt_idx_c;
  logic                   tgt_any_c;
  logic                   hs_c;
  sq_mask_t               tgt_clr_c;
  sq_mask_t               emit_c;

  lsb_index_enc u_rem_enc (
    .mask_i    (remaining_q),
    .index_c_o (rem_idx_c),
    .any_c_o   (rem_any_c)
  );

  // Encoding the next target set lets the registered move output track each handshake.
  lsb_index_enc u_tgt_enc (
    .mask_i    (tgt_d),
    .index_c_o (tgt_idx_c),
    .any_c_o   (tgt_any_c)
  );

  assign hs_c      = o_move_valid & i_move_ready;
  assign tgt_clr_c = tgt_q & ~(SQ_ONE << o_move_to);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tgt_d       = tgt_q;
    origin_d    = origin_q;
    cnt_d       = cnt_q;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            remaining_d = i_play_mask;
            state_d     = ST_ATTACK;
          end
        end
        ST_ATTACK: state_d = ST_SCAN;
        ST_SCAN: begin
          if (!rem_any_c) begin
            state_d = ST_DONE;
          end else begin
            origin_d    = rem_idx_c;
            remaining_d = remaining_q & ~(SQ_ONE << rem_idx_c);
            cnt_d       = CNT_W'(SETTLE - 1);
            state_d     = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            tgt_d   = i_target;
            state_d = ST_EMIT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_EMIT: begin
          if (tgt_q == '0) begin
            state_d = ST_SCAN;
          end else if (hs_c) begin
            tgt_d = tgt_clr_c;
            if (tgt_clr_c == '0) state_d = ST_SCAN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    emit_c = '0;
    if (state_d == ST_SETTLE) emit_c = SQ_ONE << origin_d;
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      remaining_q      <= '0;
      tgt_q            <= '0;
      origin_q         <= '0;
      cnt_q            <= '0;
      o_load_attackers <= 1'b0;
      o_emit_move      <= '0;
      o_move_valid     <= 1'b0;
      o_move_from      <= '0;
      o_move_to        <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      state_q          <= state_d;
      remaining_q      <= remaining_d;
      tgt_q            <= tgt_d;
      origin_q         <= origin_d;
      cnt_q            <= cnt_d;
      o_load_attackers <= (state_d == ST_ATTACK);
      o_emit_move      <= emit_c;
      o_move_valid     <= (state_d == ST_EMIT) && tgt_any_c;
      o_move_from      <= origin_d;
      o_move_to        <= tgt_idx_c;
      o_busy           <= (state_d != ST_IDLE);
      o_done           <= (state_d == ST_DONE);
    end
  end

`ifdef MOVEGEN_MOVE_COUNT_EN
  logic                  start_acc_c;
  logic [MOVE_CNT_W-1:0] move_count_q;

  assign start_acc_c = (state_q == ST_IDLE) && i_start && !i_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_count_q <= '0;
    end else if (start_acc_c) begin
      move_count_q <= '0;
    end else if (hs_c && (move_count_q != '1)) begin
      move_count_q <= move_count_q + MOVE_CNT_W'(1);
    end
  end

  assign o_move_count = move_count_q;
`endif

endmodule

// File: tb/tb_movegen_sequencer.sv
// Scoreboard bench: square-array model drives i_target, monitor checks the move stream.
module tb_movegen_sequencer;
  import movegen_pkg::*;

  localparam int unsigned SETTLE = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic [63:0]       i_play_mask = '0;
  logic              o_load_attackers;
  logic [63:0]       o_emit_move;
  logic [63:0]       i_target;
  logic              o_move_valid;
  logic              i_move_ready = 1'b1;
  logic [SQ_W-1:0]   o_move_from;
  logic [SQ_W-1:0]   o_move_to;
  logic              o_busy;
  logic              o_done;
`ifdef MOVEGEN_MOVE_COUNT_EN
  logic [6:0]        o_move_count;
`endif

  movegen_sequencer #(.SETTLE(SETTLE)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_play_mask      (i_play_mask),
    .o_load_attackers (o_load_attackers),
    .o_emit_move      (o_emit_move),
    .i_target         (i_target),
    .o_move_valid     (o_move_valid),
    .i_move_ready     (i_move_ready),
    .o_move_from      (o_move_from),
    .o_move_to        (o_move_to),
    .o_busy           (o_busy),
    .o_done           (o_done)
`ifdef MOVEGEN_MOVE_COUNT_EN
    ,
    .o_move_count     (o_move_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic [63:0]         tab [64];
  int                  pc [64];
  logic [2*SQ_W-1:0]   exp_q [$];
  logic [2*SQ_W-1:0]   rx [$];
  int done_cnt, load_cnt, valid_cnt, emit1_cnt;
  int first_load_cyc, done_cyc, last_hs_cyc, start_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Square-array stand-in: the selected origin's target set, nothing when not one-hot.
  always_comb begin
    i_target = '0;
    for (int s = 0; s < 64; s++) begin
      if (o_emit_move == (64'h1 << s)) i_target = tab[s];
    end
  end

  function automatic logic [63:0] chess_targets(input int sq);
    logic [63:0] m;
    int r, f, p, ar, af, rr, ff;
    bit diag;
    m = '0;
    r = sq / 8;
    f = sq % 8;
    p = pc[sq];
    if (p == 1) begin
      if (r < 7 && pc[sq+8] == 0) begin
        m[sq+8] = 1'b1;
        if (r == 1 && pc[sq+16] == 0) m[sq+16] = 1'b1;
      end
      if (r < 7 && f > 0 && pc[sq+7] < 0) m[sq+7] = 1'b1;
      if (r < 7 && f < 7 && pc[sq+9] < 0) m[sq+9] = 1'b1;
    end
    for (int dr = -2; dr <= 2; dr++) begin
      for (int df = -2; df <= 2; df++) begin
        ar = (dr < 0) ? -dr : dr;
        af = (df < 0) ? -df : df;
        rr = r + dr;
        ff = f + df;
        if (rr >= 0 && rr < 8 && ff >= 0 && ff < 8 && pc[rr*8+ff] <= 0) begin
          if ((p == 2 && ar * af == 2) || (p == 6 && ar <= 1 && af <= 1 && (ar + af) > 0))
            m[rr*8+ff] = 1'b1;
        end
      end
    end
    for (int dr = -1; dr <= 1; dr++) begin
      for (int df = -1; df <= 1; df++) begin
        diag = (dr != 0 && df != 0);
        if ((dr != 0 || df != 0) && ((p == 3 && diag) || (p == 4 && !diag) || p == 5)) begin
          rr = r + dr;
          ff = f + df;
          while (rr >= 0 && rr < 8 && ff >= 0 && ff < 8) begin
            if (pc[rr*8+ff] <= 0) m[rr*8+ff] = 1'b1;
            if (pc[rr*8+ff] != 0) break;
            rr += dr;
            ff += df;
          end
        end
      end
    end
    return m;
  endfunction

  task automatic tab_from_board();
    for (int s = 0; s < 64; s++) tab[s] = (pc[s] > 0) ? chess_targets(s) : 64'h0;
  endtask

  task automatic set_start_board();
    int back [8];
    back = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int s = 0; s < 64; s++) pc[s] = 0;
    for (int f = 0; f < 8; f++) begin
      pc[f]      = back[f];
      pc[8 + f]  = 1;
      pc[48 + f] = -1;
      pc[56 + f] = -back[f];
    end
    tab_from_board();
  endtask

  task automatic start_run(input logic [63:0] mask);
    exp_q.delete();
    for (int o = 0; o < 64; o++)
      if (mask[o])
        for (int t = 0; t < 64; t++)
          if (tab[o][t]) exp_q.push_back({SQ_W'(o), SQ_W'(t)});
    rx.delete();
    done_cnt = 0; load_cnt = 0; valid_cnt = 0; emit1_cnt = 0;
    first_load_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
    @(posedge clk); #1;
    i_play_mask = mask;
    i_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: one 5-cycle stall on the first move
  task automatic wait_done(input string nm, input int mode, input int budget);
    int n, bp_left;
    bit bp_done;
    logic [2*SQ_W-1:0] bp_mv;
    n = 0; bp_left = 0; bp_done = 0; bp_mv = '0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (bp_left > 0) begin
        chk({nm, " stall valid"}, o_move_valid, 1);
        chk({nm, " stall move"}, {o_move_from, o_move_to}, bp_mv);
        bp_left--;
      end else if (mode == 2 && !bp_done && o_move_valid) begin
        bp_done = 1; bp_left = 5; bp_mv = {o_move_from, o_move_to};
      end
      i_move_ready = (bp_left > 0) ? 1'b0 : ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    i_move_ready = 1'b1;
    chk({nm, " done seen"}, done_cnt != 0, 1);
    if (done_cnt == 0) begin
      i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
    end
    @(posedge clk); #1;
    chk({nm, " all moves seen"}, exp_q.size(), 0);
    chk({nm, " single done"}, done_cnt, 1);
    chk({nm, " single load"}, load_cnt, 1);
  endtask

  // Monitor: scoreboard pops on each handshake, plus event bookkeeping.
  initial begin
    logic [2*SQ_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_load_attackers) begin
          load_cnt++;
          if (first_load_cyc < 0) first_load_cyc = cyc;
        end
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (o_emit_move == 64'h1) emit1_cnt++;
        if (o_emit_move != '0) chk("emit onehot", $onehot(o_emit_move), 1);
        if (o_move_valid) valid_cnt++;
        if (o_move_valid && i_move_ready) begin
          rx.push_back({o_move_from, o_move_to});
          last_hs_cyc = cyc;
          chk("move expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("move", {o_move_from, o_move_to}, e);
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [63:0] m;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst valid", o_move_valid, 0);
    chk("rst emit", o_emit_move, 0);
    chk("rst load", o_load_attackers, 0);
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk("rst from/to", {o_move_from, o_move_to}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", o_busy, 0);

    // Empty play mask: load, scan, done.
    for (int s = 0; s < 64; s++) tab[s] = '0;
    start_run(64'h0);
    wait_done("empty", 0, 50);
    chk("empty load cycle", first_load_cyc - start_cyc, 1);
    chk("empty done cycle", done_cyc - start_cyc, 3);
    chk("empty no valid", valid_cnt, 0);

    // Start position.
    set_start_board();
    start_run(64'h0000_0000_0000_FFFF);
    wait_done("startpos", 0, 500);
    chk("startpos count", rx.size(), 20);
    if (rx.size() == 20) begin
      chk("startpos move1", rx[0], {sq_index(4'd1, 4'd2), sq_index(4'd3, 4'd1)});
      chk("startpos move2", rx[1], {sq_index(4'd1, 4'd2), sq_index(4'd3, 4'd3)});
      chk("startpos move20", rx[19], {sq_index(4'd2, 4'd8), sq_index(4'd4, 4'd8)});
    end
    chk("startpos done after last", done_cyc - last_hs_cyc, 2);
`ifdef MOVEGEN_MOVE_COUNT_EN
    chk("move count", o_move_count, 20);
`endif

    // Lone rook on a1.
    for (int s = 0; s < 64; s++) pc[s] = 0;
    pc[0] = 4;
    tab_from_board();
    start_run(64'h1);
    wait_done("rook", 0, 200);
    chk("rook count", rx.size(), 14);
    if (rx.size() == 14) begin
      chk("rook first", rx[0], {6'd0, 6'd1});
      chk("rook 8th", rx[7], {6'd0, 6'd8});
      chk("rook last", rx[13], {6'd0, 6'd56});
    end
    chk("rook emit cycles", emit1_cnt, SETTLE);

    // Backpressure on the start position.
    set_start_board();
    start_run(64'h0000_0000_0000_FFFF);
    wait_done("stall", 2, 500);
    chk("stall count", rx.size(), 20);

    // Abort while emitting.
    start_run(64'h0000_0000_0000_FFFF);
`ifdef MOVEGEN_MOVE_COUNT_EN
    chk("move count cleared", o_move_count, 0);
`endif
    n = 0;
    while (!o_move_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort reached emit", o_move_valid, 1);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    chk("abort valid", o_move_valid, 0);
    chk("abort emit", o_emit_move, 0);
    chk("abort busy", o_busy, 0);
    repeat (6) @(posedge clk);
    chk("abort no done", done_cnt, 0);

    // Reset while an origin is settling.
    start_run(64'h0000_0000_0000_FFFF);
    n = 0;
    while (o_emit_move == '0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reset reached settle", o_emit_move != '0, 1);
    rst = 1'b1;
    #1;
    chk("midrst emit", o_emit_move, 0);
    chk("midrst valid", o_move_valid, 0);
    chk("midrst busy", o_busy, 0);
    chk("midrst done", o_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_run(64'h0000_0000_0000_FFFF);
    wait_done("rerun", 0, 500);
    chk("rerun count", rx.size(), 20);

    // Random masks and target tables with random ready.
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < 64; s++)
        tab[s] = ($urandom_range(0, 3) == 0) ? 64'h0 :
                 ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      m = {$urandom, $urandom} & {$urandom, $urandom};
      start_run(m);
      wait_done("random", (k % 3 == 2) ? 2 : 1, 20000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
